// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared types and sizes for the instruction-fetch slice.
//   fetch_state_t : fetch sequencer state (RUN / HALTED)
//   IMEM_WORDS    : number of instruction memory words
//   IMEM_AW       : word-address width
//   INSTR_W       : instruction width in bits
// ---------------------------------------------------------------------------
package imem_pkg;

   localparam int unsigned IMEM_WORDS = 256;
   localparam int unsigned IMEM_AW    = 8;
   localparam int unsigned INSTR_W    = 32;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles every non-clock/reset signal of the fetch sequencer.
//   mem_a / mem_d                   : asynchronous instruction memory port
//   redirect_valid / redirect_addr  : PC load request (branch/jump)
//   halt / resume                   : run-control pulses
//   instr_valid / instr / instr_pc  : output register toward decode
//   instr_ready                     : decode accepts the current instruction
//   halted                          : sequencer is in HALTED
// master : the fetch sequencer.  slave : memory + decode + control side.
// ---------------------------------------------------------------------------
interface imem_fetch_ctrl_if
   import imem_pkg::*;
#(
   parameter int unsigned S  = INSTR_W,
   parameter int unsigned AW = IMEM_AW
);

   logic [AW-1:0] mem_a;
   logic [S-1:0]  mem_d;
   logic          redirect_valid;
   logic [AW-1:0] redirect_addr;
   logic          halt;
   logic          resume;
   logic          instr_valid;
   logic [S-1:0]  instr;
   logic [AW-1:0] instr_pc;
   logic          instr_ready;
   logic          halted;

   modport master (
      output mem_a,
      input  mem_d,
      input  redirect_valid,
      input  redirect_addr,
      input  halt,
      input  resume,
      output instr_valid,
      output instr,
      output instr_pc,
      input  instr_ready,
      output halted
   );

   modport slave (
      input  mem_a,
      output mem_d,
      output redirect_valid,
      output redirect_addr,
      output halt,
      output resume,
      input  instr_valid,
      input  instr,
      input  instr_pc,
      output instr_ready,
      input  halted
   );

endinterface

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Program counter: word address, wraps from L-1 to 0.
//   clk       : clock
//   reset     : synchronous active-high reset, loads START
//   load      : load load_addr (takes priority over inc)
//   load_addr : new PC value
//   inc       : advance to the next word
//   pc        : current program counter
// ---------------------------------------------------------------------------
module pc_reg #(
   parameter int unsigned L     = 256,
   parameter int unsigned AW    = 8,
   parameter int unsigned START = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [AW-1:0] load_addr,
   input  logic          inc,
   output logic [AW-1:0] pc
);

   localparam logic [AW-1:0] LAST_PC  = AW'(L - 1);
   localparam logic [AW-1:0] START_PC = AW'(START);

   // NOTE: registers are written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= START_PC;
      end else if (load) begin
         pc <= load_addr;
      end else if (inc) begin
         // Explicit wrap keeps non-power-of-two depths correct.
         pc <= (pc == LAST_PC) ? '0 : pc + AW'(1);
      end
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch sequencer: owns the PC, reads the asynchronous memory,
// and holds one instruction for decode under a valid/ready handshake.
// Supports backpressure, redirect (flush + PC load) and halt/resume.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : imem_fetch_ctrl_if.master (memory, control and decode signals)
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter int unsigned S     = INSTR_W,
   parameter int unsigned L     = IMEM_WORDS,
   parameter int unsigned AW    = $clog2(L),
   parameter int unsigned START = 0
) (
   input  logic                clk,
   input  logic                reset,
   imem_fetch_ctrl_if.master   bus
);

   fetch_state_t  state_q, state_d;
   logic [AW-1:0] pc;
   logic          fe;
   logic          xfer;

   logic          valid_q;
   logic [S-1:0]  instr_q;
   logic [AW-1:0] instr_pc_q;

   assign xfer = valid_q && bus.instr_ready;

   pc_reg #(
      .L     (L),
      .AW    (AW),
      .START (START)
   ) u_pc (
      .clk       (clk),
      .reset     (reset),
      .load      (bus.redirect_valid),
      .load_addr (bus.redirect_addr),
      .inc       (fe),
      .pc        (pc)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      fe      = 1'b0;
      case (state_q)
         RUN: begin
            // A halt cycle issues no fetch; redirect also blocks it (bubble).
            fe = !bus.redirect_valid && !bus.halt && (!valid_q || bus.instr_ready);
            if (bus.halt) state_d = HALTED;
         end
         HALTED: begin
            // Halt wins over a same-cycle resume.
            if (bus.resume && !bus.halt) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Output register: redirect flushes, fetch refills, transfer empties.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else if (bus.redirect_valid) begin
         valid_q <= 1'b0;
      end else if (fe) begin
         valid_q    <= 1'b1;
         instr_q    <= bus.mem_d;
         instr_pc_q <= pc;
      end else if (xfer) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.mem_a       = pc;
   assign bus.instr_valid = valid_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.halted      = (state_q == HALTED);

endmodule
